dcache_bank: RTL

Parametrised successor to the single-bank data cache. A word-addressed data store serves LDR and STR micro-ops from the execute stage over a valid/ready request port and a one-cycle response pulse. Stores are byte-enabled and committed through a one-entry store buffer, with load forwarding. A reset-time clear sweep leaves every entry at zero before the first request is accepted.

---
 rtl/dcache_bank.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dcache_bank.sv
// Word-addressed data cache bank: valid/ready LDR/STR port, byte-enabled stores
// committed through a one-entry store buffer with load forwarding, reset-time clear sweep.
package Utilities;
    localparam logic [4:0] LDR = 5'd1;
    localparam logic [4:0] STR = 5'd2;
endpackage

module dcache_bank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [4:0]              req_uop,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_data,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    busy
);

    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t state, state_next;
    logic [ADDR_WIDTH:0] sweep_cnt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  sb_valid;
    logic [ADDR_WIDTH-1:0] sb_addr;
    logic [DATA_WIDTH-1:0] sb_data;
    logic [NB-1:0]         sb_be;

    logic                  accept, is_ldr, is_str;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NB-1:0]         wr_be;
    logic [DATA_WIDTH-1:0] ld_word;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= (INIT_CLEAR != 0) ? INIT : READY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        busy       = 1'b0;
        case (state)
            INIT: begin
                busy = 1'b1;
                if (sweep_cnt == LAST) begin
                    state_next = READY;
                end
            end
            READY: begin
                req_ready = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sweep_cnt <= '0;
        end else if (state == INIT) begin
            sweep_cnt <= sweep_cnt + (ADDR_WIDTH + 1)'(1);
        end
    end

    assign accept = req_valid && req_ready;
    assign is_ldr = (req_uop == Utilities::LDR);
    assign is_str = (req_uop == Utilities::STR);

    // Buffer valid only for the cycle after capture; the drain is that next edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sb_valid <= 1'b0;
            sb_addr  <= '0;
            sb_data  <= '0;
            sb_be    <= '0;
        end else begin
            sb_valid <= accept && is_str;
            if (accept && is_str) begin
                sb_addr <= req_addr;
                sb_data <= req_data;
                sb_be   <= req_be;
            end
        end
    end

    // Single write port shared by sweep and drain; never both since INIT takes no requests.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = sb_addr;
        wr_data = sb_data;
        wr_be   = sb_be;
        if (state == INIT) begin
            wr_en   = 1'b1;
            wr_addr = sweep_cnt[ADDR_WIDTH-1:0];
            wr_data = '0;
            wr_be   = '1;
        end else if (sb_valid) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Merge uses the pre-edge buffer, so a load accepted on the drain edge still forwards.
    always_comb begin
        ld_word = mem[req_addr];
        for (int unsigned i = 0; i < NB; i++) begin
            if (sb_valid && (sb_addr == req_addr) && sb_be[i]) begin
                ld_word[8*i +: 8] = sb_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= accept && is_ldr;
            if (accept) begin
                if (is_ldr) begin
                    rsp_data <= ld_word;
                end else if (!is_str) begin
                    rsp_data <= '0;
                end
            end
        end
    end

endmodule
